// File: rtl/twilight_cat_pkg.sv
// Shared event encoding between the button conditioner and the animation controller.
package twilight_cat_pkg;

  localparam logic [1:0] EVT_PRESS    = 2'd0;
  localparam logic [1:0] EVT_SHORT    = 2'd1;
  localparam logic [1:0] EVT_LONG     = 2'd2;
  localparam logic [1:0] EVT_LONG_END = 2'd3;

  localparam int NUM_KIND = 4;

  typedef enum logic [1:0] {
    CLS_IDLE      = 2'd0,
    CLS_HELD      = 2'd1,
    CLS_LONG_HELD = 2'd2
  } cls_state_e;

endpackage

// File: rtl/twilight_cat_btn_debounce.sv
// One button: 2-flop synchroniser, debounce counter and press/hold classifier.
// Events are raised in the cycle the debounced level is about to flip.
//
// state         | meaning
// CLS_IDLE      | button released, waiting for a debounced press
// CLS_HELD      | pressed, hold timer running
// CLS_LONG_HELD | held past the long threshold, waiting for release
module twilight_cat_btn_debounce
  import twilight_cat_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int LONG_CYCLES     = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  output logic       btn_level,
  output logic [3:0] evt_raise
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = '1;

  logic              sync1_q, sync2_q;
  logic              level_q, level_d;
  logic [DEB_W-1:0]  cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  cls_state_e        state_q, state_d;
  logic              rise, fall;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == DEB_LAST) level_d = sync2_q;
      else                   cnt_d   = cnt_q + 1'b1;
    end
    rise = level_d & ~level_q;
    fall = ~level_d & level_q;
  end

  // A release on the long-threshold cycle wins, so that press is reported as SHORT.
  always_comb begin
    state_d   = state_q;
    hold_d    = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
    evt_raise = '0;
    unique case (state_q)
      CLS_IDLE: begin
        hold_d = '0;
        if (rise) begin
          state_d              = CLS_HELD;
          evt_raise[EVT_PRESS] = 1'b1;
        end
      end
      CLS_HELD: begin
        if (fall) begin
          state_d              = CLS_IDLE;
          evt_raise[EVT_SHORT] = 1'b1;
        end else if (hold_q == HOLD_LAST) begin
          state_d             = CLS_LONG_HELD;
          evt_raise[EVT_LONG] = 1'b1;
        end
      end
      CLS_LONG_HELD: begin
        if (fall) begin
          state_d                 = CLS_IDLE;
          evt_raise[EVT_LONG_END] = 1'b1;
        end
      end
      default: state_d = CLS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      hold_q  <= '0;
      state_q <= CLS_IDLE;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      state_q <= state_d;
    end
  end

  assign btn_level = level_q;

endmodule

// File: rtl/twilight_cat_btn_events.sv
// Button event producer: per-button conditioners feed a pending bitmap drained
// one event at a time, lowest btn*4+kind first, through a valid/ready register.
module twilight_cat_btn_events
  import twilight_cat_pkg::*;
#(
  parameter  int NUM_BTN         = 4,
  parameter  int DEBOUNCE_CYCLES = 10000,
  parameter  int LONG_CYCLES     = 5000000,
  localparam int BTN_W           = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [BTN_W-1:0]   evt_btn,
  output logic [1:0]         evt_kind,
  output logic               overflow
);

  localparam int NUM_EVT = NUM_BTN * NUM_KIND;
  localparam int IDX_W   = $clog2(NUM_EVT);

  logic [NUM_EVT-1:0] raise;
  logic [NUM_EVT-1:0] pending_q, pending_d;
  logic               valid_q, valid_d;
  logic [BTN_W-1:0]   evt_btn_q, evt_btn_d;
  logic [1:0]         evt_kind_q, evt_kind_d;
  logic               overflow_q, overflow_d;
  logic               grant_vld, load;
  logic [IDX_W-1:0]   grant_idx;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    twilight_cat_btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_btn (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_raw[g]),
      .btn_level (btn_level[g]),
      .evt_raise (raise[g*NUM_KIND +: NUM_KIND])
    );
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = NUM_EVT - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
  end

  // A bit granted this cycle may be re-raised without counting as a loss.
  always_comb begin
    load       = grant_vld && (!valid_q || evt_ready);
    pending_d  = pending_q;
    valid_d    = valid_q;
    evt_btn_d  = evt_btn_q;
    evt_kind_d = evt_kind_q;
    overflow_d = overflow_q;
    if (load) begin
      pending_d[grant_idx] = 1'b0;
      valid_d              = 1'b1;
      evt_btn_d            = BTN_W'(grant_idx >> 2);
      evt_kind_d           = grant_idx[1:0];
    end else if (valid_q && evt_ready) begin
      valid_d = 1'b0;
    end
    for (int i = 0; i < NUM_EVT; i++) begin
      if (raise[i]) begin
        if (pending_q[i] && !(load && grant_idx == IDX_W'(i))) overflow_d = 1'b1;
        pending_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      valid_q    <= 1'b0;
      evt_btn_q  <= '0;
      evt_kind_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      valid_q    <= valid_d;
      evt_btn_q  <= evt_btn_d;
      evt_kind_q <= evt_kind_d;
      overflow_q <= overflow_d;
    end
  end

  assign evt_valid = valid_q;
  assign evt_btn   = evt_btn_q;
  assign evt_kind  = evt_kind_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_twilight_cat_btn_events.sv
// Bench for twilight_cat_btn_events: table of press lengths plus hand sequences,
// with an event scoreboard drained on every handshake.
module tb_twilight_cat_btn_events;
  import twilight_cat_pkg::*;

  localparam int NB   = 4;
  localparam int DEB  = 4;
  localparam int LONG = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic          evt_valid;
  logic          evt_ready;
  logic [1:0]    evt_btn;
  logic [1:0]    evt_kind;
  logic          overflow;

  twilight_cat_btn_events #(
    .NUM_BTN         (NB),
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONG)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_btn   (evt_btn),
    .evt_kind  (evt_kind),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] btn;
    logic [1:0] kind;
  } evt_t;

  typedef struct {
    int   btn;
    int   hold;
    logic exp_long;
  } vec_t;

  evt_t exp_q[$];
  evt_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   hs_cyc[4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int b, input logic [1:0] k);
    evt_t e;
    e.btn  = 2'(b);
    e.kind = k;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) step(1);
    check("drain_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Scoreboard: every handshake must match the next expected event.
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL evt_unexpected: got btn=%0d kind=%0d expected none (cycle %0d)",
                 evt_btn, evt_kind, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if ({evt_btn, evt_kind} !== {mon_e.btn, mon_e.kind}) begin
          n_bad++;
          $display("FAIL evt_seq: got btn=%0d kind=%0d expected btn=%0d kind=%0d (cycle %0d)",
                   evt_btn, evt_kind, mon_e.btn, mon_e.kind, cyc);
        end
      end
      hs_cyc[evt_kind] = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   bad_cnt;
    vecs[0] = '{btn: 1, hold: 19, exp_long: 1'b0};
    vecs[1] = '{btn: 3, hold: 20, exp_long: 1'b0};
    vecs[2] = '{btn: 3, hold: 21, exp_long: 1'b1};
    vecs[3] = '{btn: 0, hold: 40, exp_long: 1'b1};

    rst       = 1'b1;
    btn_raw   = '0;
    evt_ready = 1'b0;
    step(3);
    check("rst_level", btn_level, 0);
    check("rst_valid", evt_valid, 0);
    check("rst_btn", evt_btn, 0);
    check("rst_kind", evt_kind, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;
    step(1);

    // Glitch shorter than the debounce window.
    btn_raw[1] = 1'b1;
    step(3);
    btn_raw[1] = 1'b0;
    bad_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (btn_level != '0 || evt_valid) bad_cnt++;
    end
    check("glitch_seen", bad_cnt, 0);

    // Latency of a short press.
    evt_ready  = 1'b1;
    btn_raw[2] = 1'b1;
    push(2, EVT_PRESS);
    push(2, EVT_SHORT);
    step(5);
    check("lat_lvl_early", btn_level[2], 0);
    step(1);
    check("lat_lvl", btn_level[2], 1);
    check("lat_valid_early", evt_valid, 0);
    step(1);
    check("lat_press", {evt_valid, evt_btn, evt_kind}, {1'b1, 2'd2, EVT_PRESS});
    step(3);
    btn_raw[2] = 1'b0;
    wait_drain(30);
    step(10);

    // Hold lengths around the long threshold.
    for (int v = 0; v < 4; v++) begin
      push(vecs[v].btn, EVT_PRESS);
      if (vecs[v].exp_long) begin
        push(vecs[v].btn, EVT_LONG);
        push(vecs[v].btn, EVT_LONG_END);
      end else begin
        push(vecs[v].btn, EVT_SHORT);
      end
      btn_raw[vecs[v].btn] = 1'b1;
      step(vecs[v].hold);
      btn_raw[vecs[v].btn] = 1'b0;
      wait_drain(40);
      if (vecs[v].exp_long)
        check("long_delay", hs_cyc[EVT_LONG] - hs_cyc[EVT_PRESS], LONG);
      step(10);
    end

    // Simultaneous presses while stalled.
    evt_ready  = 1'b0;
    btn_raw[3] = 1'b1;
    btn_raw[1] = 1'b1;
    push(1, EVT_PRESS);
    push(3, EVT_PRESS);
    push(1, EVT_SHORT);
    push(3, EVT_SHORT);
    step(8);
    for (int i = 0; i < 5; i++) begin
      check("stall_hold", {evt_valid, evt_btn, evt_kind}, {1'b1, 2'd1, EVT_PRESS});
      step(1);
    end
    evt_ready = 1'b1;
    step(1);
    check("b2b_next", {evt_valid, evt_btn, evt_kind}, {1'b1, 2'd3, EVT_PRESS});
    step(1);
    btn_raw[3] = 1'b0;
    btn_raw[1] = 1'b0;
    wait_drain(40);
    check("simul_ovf", overflow, 0);
    step(10);

    // Collision in the pending bitmap while stalled.
    evt_ready  = 1'b0;
    btn_raw[0] = 1'b1;
    step(8);
    btn_raw[0] = 1'b0;
    step(14);
    check("ovf_before", overflow, 0);
    btn_raw[0] = 1'b1;
    step(8);
    btn_raw[0] = 1'b0;
    step(14);
    check("ovf_set", overflow, 1);
    push(0, EVT_PRESS);
    push(0, EVT_PRESS);
    push(0, EVT_SHORT);
    step(5);
    evt_ready = 1'b1;
    wait_drain(20);
    step(10);
    check("ovf_sticky", overflow, 1);

    // Reset while in the long-held state with the button still down.
    btn_raw[1] = 1'b1;
    push(1, EVT_PRESS);
    push(1, EVT_LONG);
    step(35);
    wait_drain(10);
    rst = 1'b1;
    step(1);
    check("mid_rst_level", btn_level, 0);
    check("mid_rst_valid", evt_valid, 0);
    check("mid_rst_btn", evt_btn, 0);
    check("mid_rst_kind", evt_kind, 0);
    check("mid_rst_ovf", overflow, 0);
    rst = 1'b0;
    push(1, EVT_PRESS);
    step(5);
    check("rerst_lvl_early", btn_level[1], 0);
    step(1);
    check("rerst_lvl", btn_level[1], 1);
    check("rerst_valid_early", evt_valid, 0);
    step(1);
    check("rerst_press", {evt_valid, evt_btn, evt_kind}, {1'b1, 2'd1, EVT_PRESS});
    btn_raw[1] = 1'b0;
    push(1, EVT_SHORT);
    wait_drain(30);
    step(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
